// File: rtl/icache_tag_word_select_if.sv
// Lookup/fill bus between the icache lookup core and its users.
// The CPU and controller drive the PC and fill port; the core returns the hit, miss and instruction word.
interface icache_tag_word_select_if #(
  parameter int IDX_W   = 3,
  parameter int TAG_W   = 3,
  parameter int BLOCK_W = 128
);
  logic [31:0]        address_pc;
  logic               fill_en;
  logic [IDX_W-1:0]   fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic [BLOCK_W-1:0] fill_data;
  logic [31:0]        instruction;
  logic               hit;
  logic               miss;
  logic [TAG_W-1:0]   line_tag;

  modport master (
    output address_pc, fill_en, fill_index, fill_tag, fill_data,
    input  instruction, hit, miss, line_tag
  );

  modport slave (
    input  address_pc, fill_en, fill_index, fill_tag, fill_data,
    output instruction, hit, miss, line_tag
  );
endinterface

// File: rtl/icache_tag_word_select.sv
// Direct-mapped icache lookup core: tag/valid/data arrays, a combinational tag compare
// and word select, and a one-cycle fill port driven by the icache controller.
module icache_tag_word_select #(
  parameter int NUM_LINES = 8,
  parameter int TAG_W     = 3,
  parameter int BLOCK_W   = 128
) (
  input  logic clock,
  input  logic reset,
  icache_tag_word_select_if.slave bus
);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int WORD_W  = 32;
  localparam int OFF_LSB = 2;
  localparam int IDX_LSB = 4;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam logic [31:0] NO_FETCH_PC = 32'hFFFF_FFFC;

  function automatic logic [WORD_W-1:0] select_word(input logic [BLOCK_W-1:0] blk,
                                                    input logic [1:0]         off);
    logic [WORD_W-1:0] w;
    case (off)
      2'd0:    w = blk[WORD_W-1:0];
      2'd1:    w = blk[2*WORD_W-1:WORD_W];
      2'd2:    w = blk[3*WORD_W-1:2*WORD_W];
      default: w = blk[4*WORD_W-1:3*WORD_W];
    endcase
    return w;
  endfunction

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_q [NUM_LINES];
  logic [BLOCK_W-1:0]   data_d [NUM_LINES];

  logic [IDX_W-1:0]   pc_index;
  logic [TAG_W-1:0]   pc_tag;
  logic [1:0]         pc_offset;
  logic [BLOCK_W-1:0] line_data;
  logic [TAG_W-1:0]   line_tag_rd;
  logic               tag_equal;
  logic               lookup_req;
  logic               hit_int;

  // Fill port: at most one line changes per edge, all others hold.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (bus.fill_en) begin
      valid_d[bus.fill_index] = 1'b1;
      tag_d[bus.fill_index]   = bus.fill_tag;
      data_d[bus.fill_index]  = bus.fill_data;
    end
  end

  // Storage is cleared on reset too, so the read path never exposes X.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  // Read path is purely combinational; a same-index fill is visible right after its edge.
  always_comb begin
    pc_index    = bus.address_pc[IDX_LSB +: IDX_W];
    pc_tag      = bus.address_pc[TAG_LSB +: TAG_W];
    pc_offset   = bus.address_pc[OFF_LSB +: 2];
    line_data   = data_q[pc_index];
    line_tag_rd = tag_q[pc_index];
    tag_equal   = (line_tag_rd == pc_tag);
    hit_int     = valid_q[pc_index] & tag_equal;
    lookup_req  = (bus.address_pc != NO_FETCH_PC);
  end

  // The word is driven even on a miss; the consumer qualifies it with hit.
  assign bus.instruction = select_word(line_data, pc_offset);
  assign bus.hit         = hit_int;
  assign bus.miss        = lookup_req & ~hit_int;
  assign bus.line_tag    = line_tag_rd;
endmodule

// File: tb/tb_icache_tag_word_select.sv
// Directed bench for the icache lookup core: reset, word select, tag mismatch,
// same-edge refill and back-to-back fills with a reset pulse in the middle.
module tb_icache_tag_word_select;
  logic clock;
  logic reset;
  int   passed;
  int   total;

  icache_tag_word_select_if #(.IDX_W(3), .TAG_W(3), .BLOCK_W(128)) bus ();

  icache_tag_word_select #(.NUM_LINES(8), .TAG_W(3), .BLOCK_W(128)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_fill(input logic [2:0] idx, input logic [2:0] tg, input logic [127:0] d);
    @(negedge clock);
    bus.fill_en    = 1'b1;
    bus.fill_index = idx;
    bus.fill_tag   = tg;
    bus.fill_data  = d;
    @(negedge clock);
    bus.fill_en    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    bus.address_pc = 32'h0000_0000;
    #1;
    total++; if (bus.hit !== 1'b0) $display("FAIL rst_hit got %b want 0", bus.hit); else passed++;
    total++; if (bus.miss !== 1'b1) $display("FAIL rst_miss got %b want 1", bus.miss); else passed++;
    total++; if (bus.instruction !== 32'h0) $display("FAIL rst_instr got %h want 0", bus.instruction); else passed++;
    total++; if (bus.line_tag !== 3'h0) $display("FAIL rst_line_tag got %h want 0", bus.line_tag); else passed++;
    bus.address_pc = 32'hFFFF_FFFC;
    #1;
    total++; if (bus.miss !== 1'b0) $display("FAIL rst_nofetch_miss got %b want 0", bus.miss); else passed++;
    total++; if (bus.hit !== 1'b0) $display("FAIL rst_nofetch_hit got %b want 0", bus.hit); else passed++;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_word_select();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h1111_1111;
    exp_w[1] = 32'h2222_2222;
    exp_w[2] = 32'h3333_3333;
    exp_w[3] = 32'h4444_4444;
    do_fill(3'd0, 3'd0, 128'h44444444_33333333_22222222_11111111);
    for (int k = 0; k < 4; k++) begin
      bus.address_pc = 32'(k * 4);
      #1;
      total++; if (bus.hit !== 1'b1) $display("FAIL word_hit[%0d] got %b want 1", k, bus.hit); else passed++;
      total++; if (bus.miss !== 1'b0) $display("FAIL word_miss[%0d] got %b want 0", k, bus.miss); else passed++;
      total++;
      if (bus.instruction !== exp_w[k])
        $display("FAIL word_instr[%0d] got %h want %h", k, bus.instruction, exp_w[k]);
      else passed++;
    end
  endtask

  task automatic test_tag_mismatch();
    bus.address_pc = 32'h0000_0080;
    #1;
    total++; if (bus.hit !== 1'b0) $display("FAIL mism_hit got %b want 0", bus.hit); else passed++;
    total++; if (bus.miss !== 1'b1) $display("FAIL mism_miss got %b want 1", bus.miss); else passed++;
    total++; if (bus.line_tag !== 3'h0) $display("FAIL mism_line_tag got %h want 0", bus.line_tag); else passed++;
    total++;
    if (bus.instruction !== 32'h1111_1111)
      $display("FAIL mism_instr got %h want 11111111", bus.instruction);
    else passed++;
  endtask

  task automatic test_refill_same_edge();
    @(negedge clock);
    bus.address_pc = 32'h0000_0080;
    bus.fill_en    = 1'b1;
    bus.fill_index = 3'd0;
    bus.fill_tag   = 3'd1;
    bus.fill_data  = {96'h0, 32'hDEAD_BEEF};
    #1;
    total++; if (bus.hit !== 1'b0) $display("FAIL refill_pre_hit got %b want 0", bus.hit); else passed++;
    total++;
    if (bus.instruction !== 32'h1111_1111)
      $display("FAIL refill_pre_instr got %h want 11111111", bus.instruction);
    else passed++;
    @(posedge clock);
    #1;
    total++; if (bus.hit !== 1'b1) $display("FAIL refill_post_hit got %b want 1", bus.hit); else passed++;
    total++;
    if (bus.instruction !== 32'hDEAD_BEEF)
      $display("FAIL refill_post_instr got %h want deadbeef", bus.instruction);
    else passed++;
    total++; if (bus.line_tag !== 3'h1) $display("FAIL refill_line_tag got %h want 1", bus.line_tag); else passed++;
    @(negedge clock);
    bus.fill_en    = 1'b0;
    bus.address_pc = 32'h0000_0000;
    #1;
    total++; if (bus.hit !== 1'b0) $display("FAIL refill_old_hit got %b want 0", bus.hit); else passed++;
    total++; if (bus.miss !== 1'b1) $display("FAIL refill_old_miss got %b want 1", bus.miss); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      bus.fill_en    = 1'b1;
      bus.fill_index = 3'(i);
      bus.fill_tag   = 3'(i);
      bus.fill_data  = {96'h0, 32'(i)};
    end
    @(negedge clock);
    bus.fill_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      addr = (32'(i) << 4) | (32'(i) << 7);
      bus.address_pc = addr;
      #1;
      total++; if (bus.hit !== 1'b1) $display("FAIL b2b_hit[%0d] got %b want 1", i, bus.hit); else passed++;
      total++;
      if (bus.instruction !== 32'(i))
        $display("FAIL b2b_instr[%0d] got %h want %h", i, bus.instruction, 32'(i));
      else passed++;
      total++;
      if (bus.line_tag !== 3'(i))
        $display("FAIL b2b_line_tag[%0d] got %h want %h", i, bus.line_tag, 3'(i));
      else passed++;
    end
    // Reset pulse while a fill to line 5 is pending across a clock edge.
    @(negedge clock);
    bus.fill_en    = 1'b1;
    bus.fill_index = 3'd5;
    bus.fill_tag   = 3'd2;
    bus.fill_data  = {128{1'b1}};
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      addr = (32'(i) << 4) | (32'(i) << 7);
      bus.address_pc = addr;
      #1;
      total++; if (bus.hit !== 1'b0) $display("FAIL rstpulse_hit[%0d] got %b want 0", i, bus.hit); else passed++;
    end
    @(posedge clock);
    #1;
    @(negedge clock);
    reset       = 1'b1;
    bus.fill_en = 1'b0;
    bus.address_pc = 32'h0000_0150;
    #1;
    total++; if (bus.hit !== 1'b0) $display("FAIL rstfill_hit got %b want 0", bus.hit); else passed++;
    total++; if (bus.miss !== 1'b1) $display("FAIL rstfill_miss got %b want 1", bus.miss); else passed++;
    total++; if (bus.instruction !== 32'h0) $display("FAIL rstfill_instr got %h want 0", bus.instruction); else passed++;
    total++; if (bus.line_tag !== 3'h0) $display("FAIL rstfill_line_tag got %h want 0", bus.line_tag); else passed++;
    do_fill(3'd3, 3'd3, {32'hCAFE_0003, 96'h0});
    bus.address_pc = 32'h0000_01BC;
    #1;
    total++; if (bus.hit !== 1'b1) $display("FAIL postrst_hit got %b want 1", bus.hit); else passed++;
    total++;
    if (bus.instruction !== 32'hCAFE_0003)
      $display("FAIL postrst_instr got %h want cafe0003", bus.instruction);
    else passed++;
    bus.address_pc = 32'h0000_0240;
    #1;
    total++; if (bus.hit !== 1'b0) $display("FAIL postrst_other_hit got %b want 0", bus.hit); else passed++;
  endtask

  initial begin
    passed         = 0;
    total          = 0;
    reset          = 1'b1;
    bus.address_pc = 32'h0;
    bus.fill_en    = 1'b0;
    bus.fill_index = 3'd0;
    bus.fill_tag   = 3'd0;
    bus.fill_data  = '0;
    test_reset();
    test_word_select();
    test_tag_mismatch();
    test_refill_same_edge();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/icache_tag_word_select.md
Name: icache_tag_word_select

Overview:
- Lookup core of the direct-mapped instruction cache.
- Holds 8 lines of 128-bit blocks, each with a 3-bit tag and a valid bit.
- Compares the stored tag of the indexed line against the PC tag and drives hit/miss to the icache controller FSM.
- Drives the selected 32-bit instruction word to the CPU; the controller fills lines through a one-cycle write port after a memory read.

Parameters:
- NUM_LINES, 8, number of cache lines; index width is log2(NUM_LINES) = 3.
- TAG_W, 3, tag width, taken from PC bits [9:7].
- BLOCK_W, 128, line width: four 32-bit words.

Ports:
- clock  input  1  system clock; all array writes occur on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- address_pc  input  32  PC byte address. Fields: tag = [9:7], index = [6:4], word offset = [3:2]; bits [1:0] and [31:10] are ignored.
- fill_en  input  1  write the line at fill_index on the next rising clock edge.
- fill_index  input  3  line to write.
- fill_tag  input  3  tag stored with the fill.
- fill_data  input  128  block stored with the fill.
- instruction  output  32  word selected from the indexed line by the offset.
- hit  output  1  indexed line is valid and its tag equals address_pc[9:7].
- miss  output  1  lookup requested and not hit.
- line_tag  output  3  stored tag of the indexed line (debug/controller use).

Behaviour:
- Reset (reset=0), applied immediately and asynchronously:
  - all 8 valid bits, tags and data blocks cleared to 0;
  - outputs therefore read hit=0, line_tag=0, instruction=0;
  - miss=1 unless address_pc=32'hFFFF_FFFC.
  - Reset dominates fill_en.
  - Reset mid-fill: that fill is discarded.
- Read path is purely combinational from address_pc and array contents; no clock latency.
  - idx = address_pc[6:4].
- Tag compare: equality of the stored tag of line idx against address_pc[9:7], all 3 bits; output 1 on equal, 0 otherwise.
- hit = valid[idx] AND tag_equal.
  - A valid line with a tag mismatch gives hit=0.
  - An invalid line with a matching tag (e.g. 0 after reset) gives hit=0.
- Lookup request: lookup_req = (address_pc != 32'hFFFF_FFFC). The value -4 is the CPU's "no fetch yet" PC.
- miss = lookup_req AND NOT hit. When lookup_req=0, miss=0 regardless of array state.
- Word mux, on offset = address_pc[3:2]:
  - 00 -> block[31:0]
  - 01 -> block[63:32]
  - 10 -> block[95:64]
  - 11 -> block[127:96]
- instruction is driven from the indexed line whether or not hit is asserted; the consumer qualifies it with hit.
- Fill: on a rising clock edge with reset=1 and fill_en=1, line fill_index gets data=fill_data, tag=fill_tag, valid=1.
  - Only one line is written per cycle.
  - Other lines are unchanged.
  - Refilling a valid line overwrites it; this is the replacement policy.
- Fill and lookup to the same index in the same cycle: before the edge, outputs reflect the old contents; from the edge on, the new contents (hit updates within the same cycle after the edge).
- No internal state machine; sequencing (IDLE / IMEM_READ / ICACHE_UPDATE) belongs to the controller.
- No X propagation: tag and data storage never hold X after reset.

Test Plan:
- Assert reset=0 with address_pc=0x0000_0000 -> hit=0, miss=1, instruction=0, line_tag=0. Set address_pc=32'hFFFF_FFFC -> miss=0.
- Release reset; fill index 0, tag 0, data 128'h44444444_33333333_22222222_11111111. Step address_pc through 0x0, 0x4, 0x8, 0xC -> hit=1 each time, instruction = 0x11111111, 0x22222222, 0x33333333, 0x44444444.
- With line 0 filled with tag 0, set address_pc=0x080 (tag 1, index 0) -> hit=0, miss=1, line_tag=0.
- Refill index 0 with tag 1, data word0=0xDEADBEEF, then address 0x080 -> hit=1, instruction=0xDEADBEEF; address 0x000 -> hit=0.
- Fill all 8 indices (tag=index, word0=index) back to back, then read address (i<<4)|(i<<7) for each i -> hit=1, instruction=i. Pulse reset=0 mid-sequence -> all hits drop to 0 immediately, and a fill_en active during reset has no effect.
